call_scheduler: RTL and testbench
=================================

Name: call_scheduler

Overview:
- Upstream request stage for the elevator controller.
- Debounces the raw car-panel and hall call buttons and latches them as pending calls.
- Selects one target floor for each source using a SCAN policy (continue in the current direction first) and drives the controller's inside-request and outside-request floor codes.
- Clears a pending call when the controller reports the door open at that floor. Also drives the button indicator LEDs.

Parameters:
- NUM_FLOORS, 4, number of served floors; floor codes run 1..NUM_FLOORS.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a level change (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- btn_car  input  NUM_FLOORS  raw car-panel buttons; bit i = floor i+1; asynchronous
- btn_hall  input  NUM_FLOORS  raw hall call buttons; bit i = floor i+1; asynchronous
- floor  input  4  current floor code from the controller
- status_door  input  1  controller door-open status
- sos_en  input  1  controller SOS status
- req_in  output  4  selected car-call floor code to the controller inside-request input; 0 = none
- req_out  output  4  selected hall-call floor code to the controller outside-request input; 0 = none
- pending_car  output  NUM_FLOORS  latched car calls (LEDs)
- pending_hall  output  NUM_FLOORS  latched hall calls (LEDs)
- dir  output  1  scan direction; 0 = up, 1 = down

Behaviour:
- **Reset.** rst is asynchronous, active-high; clock is clk. On reset:
  - req_in=0, req_out=0, pending_car=0, pending_hall=0, dir=0.
  - Synchronizers, debounced levels and debounce counters all 0.
- **Input conditioning.**
  - Each of the 2*NUM_FLOORS buttons passes through a 2-flop synchronizer, then its own debounce counter.
  - The counter resets to 0 whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- **Press event.** A 0->1 transition of the debounced level is a press. It sets the matching pending bit on the same clock edge, unless one of these holds:
  - sos_en=1, or
  - status_door=1 and floor equals that button's floor code.
- **Clear.**
  - While status_door=1 and floor is in 1..NUM_FLOORS, pending_car[floor-1] and pending_hall[floor-1] are cleared every cycle.
  - A floor code outside that range clears nothing.
  - If a set and a clear hit the same bit in the same cycle, the clear wins.
- **SOS.** While sos_en=1:
  - All pending bits are cleared, and req_in=req_out=0 on the next edge.
  - dir holds its value.
  - Presses are discarded. Debouncing continues, so a button held through SOS exit does not register a press.
- **Selection.** Evaluated each cycle from the current registers; results registered, so one cycle latency from a pending change to req_in/req_out.
  - Let A = pending_car | pending_hall, with the current-floor bit masked.
  - next_dir:
    - stays dir if A has a bit strictly in direction dir from floor;
    - flips if A only has bits in the opposite direction;
    - holds if A is empty.
  - req_in = nearest pending_car floor (current floor masked) strictly in direction next_dir. If none, the nearest in the opposite direction. If none, 0.
  - req_out: same rule applied to pending_hall.
  - dir <= next_dir.
  - If floor is outside 1..NUM_FLOORS: no masking; "above"/"below" are computed numerically (floor 0 means all calls are above).
- **Output guarantees.**
  - req_in and req_out never equal floor.
  - Both are always 0 or a floor code in 1..NUM_FLOORS.
- **Latency.** A button held from cycle 0 sets its pending bit at edge 2+DEBOUNCE_CYCLES (±1), and appears on req_* one edge later.
- **Reset mid-operation.** All pending calls are lost; the counters restart.

Test Plan (bench overrides DEBOUNCE_CYCLES=4):
1. **Debounce.**
   - floor=1; btn_car[2] high for 3 cycles, then low -> pending_car stays 0, req_in stays 0.
   - Then held for 10 cycles -> pending_car=4'b0100 within 7 cycles; req_in=3 on the following cycle.
2. **SCAN up.**
   - floor=2, dir=0, pending_car set for floors 1 and 4 -> req_in=4, dir=0.
   - Remove the floor-4 call (door open at floor 4, then floor=4) -> req_in=1, dir=1.
3. **Clear on arrival.**
   - pending_hall=4'b1000, floor=4, status_door=1 -> pending_hall=0 next edge, req_out=0 one edge later.
   - A btn_hall[3] press during door-open is ignored.
4. **Simultaneous set/clear.**
   - Debounced press of btn_car[1] lands on the same edge as status_door=1, floor=2 -> pending_car[1] stays 0.
5. **SOS.**
   - pending_car=4'b1010, pending_hall=4'b0001, then sos_en=1 -> both 0 next edge, req_in=req_out=0.
   - New presses during SOS leave the pending bits at 0.
6. **Async reset mid-debounce and with pending calls.**
   - Assert rst between edges -> all outputs 0 immediately.
   - After release, a held button needs a full debounce period again.

Source files
------------

// File: rtl/call_scheduler.sv
// Elevator call scheduler: debounces car/hall buttons, latches pending calls
// and picks a SCAN target floor for each call source.
module call_scheduler #(
  parameter int NUM_FLOORS      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_car,
  input  logic [NUM_FLOORS-1:0] btn_hall,
  input  logic [3:0]            floor,
  input  logic                  status_door,
  input  logic                  sos_en,
  output logic [3:0]            req_in,
  output logic [3:0]            req_out,
  output logic [NUM_FLOORS-1:0] pending_car,
  output logic [NUM_FLOORS-1:0] pending_hall,
  output logic                  dir
);

  localparam int NB = 2 * NUM_FLOORS;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]         sync1_q, sync2_q, deb_q, deb_d;
  logic [CW-1:0]         cnt_q [NB];
  logic [CW-1:0]         cnt_d [NB];
  logic [NUM_FLOORS-1:0] car_q, car_d, hall_q, hall_d;
  logic [NUM_FLOORS-1:0] hit, press_car, press_hall;
  logic [3:0]            rin_q, rin_d, rout_q, rout_d;
  logic                  dir_q, dir_d;
  logic [NB-1:0]         press;

  always_comb begin
    deb_d = deb_q;
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CMAX) deb_d[b] = sync2_q[b];
        else                  cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  assign press      = deb_d & ~deb_q;
  assign press_car  = press[NUM_FLOORS-1:0];
  assign press_hall = press[NB-1:NUM_FLOORS];

  // One hot door-open floor; an out-of-range code matches nothing
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      hit[i] = status_door && (floor == 4'(i + 1));
  end

  always_comb begin
    car_d  = '0;
    hall_d = '0;
    if (!sos_en) begin
      car_d  = (car_q  | (press_car  & ~hit)) & ~hit;
      hall_d = (hall_q | (press_hall & ~hit)) & ~hit;
    end
  end

  function automatic logic [3:0] near_up(
    input logic [NUM_FLOORS-1:0] v,
    input logic [3:0]            fl
  );
    near_up = '0;
    for (int f = NUM_FLOORS; f >= 1; f--)
      if (v[f-1] && (4'(f) > fl)) near_up = 4'(f);
  endfunction

  function automatic logic [3:0] near_dn(
    input logic [NUM_FLOORS-1:0] v,
    input logic [3:0]            fl
  );
    near_dn = '0;
    for (int f = 1; f <= NUM_FLOORS; f++)
      if (v[f-1] && (4'(f) < fl)) near_dn = 4'(f);
  endfunction

  function automatic logic [3:0] pick(
    input logic [NUM_FLOORS-1:0] v,
    input logic [3:0]            fl,
    input logic                  d
  );
    logic [3:0] a, b;
    a = d ? near_dn(v, fl) : near_up(v, fl);
    b = d ? near_up(v, fl) : near_dn(v, fl);
    pick = (a != '0) ? a : b;
  endfunction

  // Strict above/below comparisons already exclude the current floor
  always_comb begin
    logic [NUM_FLOORS-1:0] all;
    logic                  any_up, any_dn;
    all    = car_q | hall_q;
    any_up = near_up(all, floor) != '0;
    any_dn = near_dn(all, floor) != '0;
    dir_d  = dir_q;
    if (!dir_q && !any_up && any_dn) dir_d = 1'b1;
    if (dir_q && !any_dn && any_up)  dir_d = 1'b0;
    rin_d  = pick(car_q, floor, dir_d);
    rout_d = pick(hall_q, floor, dir_d);
    if (sos_en) begin
      dir_d  = dir_q;
      rin_d  = '0;
      rout_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
      car_q   <= '0;
      hall_q  <= '0;
      rin_q   <= '0;
      rout_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      sync1_q <= {btn_hall, btn_car};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
      car_q   <= car_d;
      hall_q  <= hall_d;
      rin_q   <= rin_d;
      rout_q  <= rout_d;
      dir_q   <= dir_d;
    end
  end

  assign req_in       = rin_q;
  assign req_out      = rout_q;
  assign pending_car  = car_q;
  assign pending_hall = hall_q;
  assign dir          = dir_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural call model.
module tb_call_scheduler;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_car = '0, btn_hall = '0;
  logic [3:0]   floor = 4'd1;
  logic         status_door = 1'b0, sos_en = 1'b0;
  logic [3:0]   req_in, req_out;
  logic [N-1:0] pending_car, pending_hall;
  logic         dir;

  int nchk = 0;
  int nerr = 0;

  logic [2*N-1:0] m_s1, m_s2, m_deb;
  int             m_streak [2*N];
  logic [N-1:0]   m_pc, m_ph;
  int             m_rin, m_rout;
  logic           m_dir;

  call_scheduler #(.NUM_FLOORS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .btn_car(btn_car), .btn_hall(btn_hall),
    .floor(floor), .status_door(status_door), .sos_en(sos_en),
    .req_in(req_in), .req_out(req_out),
    .pending_car(pending_car), .pending_hall(pending_hall),
    .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Closest floor with a call, walking outward in one direction
  function automatic int nearest(input logic [N-1:0] v, input int fl,
                                 input logic down);
    for (int d = 1; d <= 16; d++) begin
      int f;
      f = down ? fl - d : fl + d;
      if (f >= 1 && f <= N && v[f-1]) return f;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int b = 0; b < 2*N; b++) m_streak[b] = 0;
    m_pc = '0; m_ph = '0;
    m_rin = 0; m_rout = 0; m_dir = 1'b0;
  endtask

  task automatic model_step();
    logic [2*N-1:0] rose;
    logic [N-1:0]   all;
    logic           nd, up, dn;
    int             fl, nr_in, nr_out;
    fl = int'(floor);
    rose = '0;
    // a level is accepted after D consecutive differing samples
    for (int b = 0; b < 2*N; b++) begin
      if (m_s2[b] != m_deb[b]) begin
        m_streak[b]++;
        if (m_streak[b] == D) begin
          m_deb[b] = m_s2[b];
          m_streak[b] = 0;
          rose[b] = m_deb[b];
        end
      end else m_streak[b] = 0;
    end
    m_s2 = m_s1;
    m_s1 = {btn_hall, btn_car};
    all = m_pc | m_ph;
    up = nearest(all, fl, 1'b0) != 0;
    dn = nearest(all, fl, 1'b1) != 0;
    nd = m_dir;
    if (m_dir == 1'b0 && !up && dn) nd = 1'b1;
    if (m_dir == 1'b1 && !dn && up) nd = 1'b0;
    nr_in = nearest(m_pc, fl, nd);
    if (nr_in == 0) nr_in = nearest(m_pc, fl, !nd);
    nr_out = nearest(m_ph, fl, nd);
    if (nr_out == 0) nr_out = nearest(m_ph, fl, !nd);
    if (sos_en) begin
      m_rin = 0; m_rout = 0;
      m_pc = '0; m_ph = '0;
    end else begin
      m_rin = nr_in; m_rout = nr_out; m_dir = nd;
      for (int i = 0; i < N; i++) begin
        logic at;
        at = status_door && (fl == i + 1);
        if (rose[i] && !at)   m_pc[i] = 1'b1;
        if (rose[N+i] && !at) m_ph[i] = 1'b1;
        if (at) begin
          m_pc[i] = 1'b0;
          m_ph[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pending_car", int'(pending_car), int'(m_pc));
    chk("pending_hall", int'(pending_hall), int'(m_ph));
    chk("req_in", int'(req_in), m_rin);
    chk("req_out", int'(req_out), m_rout);
    chk("dir", int'(dir), int'(m_dir));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_in"}, int'(req_in), 0);
    chk({tag, "_req_out"}, int'(req_out), 0);
    chk({tag, "_pcar"}, int'(pending_car), 0);
    chk({tag, "_phall"}, int'(pending_hall), 0);
    chk({tag, "_dir"}, int'(dir), 0);
  endtask

  task automatic idle();
    btn_car = '0; btn_hall = '0; status_door = 1'b0; sos_en = 1'b0;
    ticks(8);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // glitch shorter than the debounce window, then a real hold
    floor = 4'd1;
    btn_car = 4'b0100; ticks(3);
    btn_car = 4'b0000; ticks(6);
    chk("glitch_pcar", int'(pending_car), 0);
    chk("glitch_req_in", int'(req_in), 0);
    btn_car = 4'b0100; ticks(6);
    chk("hold_pcar", int'(pending_car), 4'b0100);
    tick();
    chk("hold_req_in", int'(req_in), 3);
    ticks(3);
    idle();

    // clear floor 3, then SCAN up from floor 2 with calls at 1 and 4
    floor = 4'd3; status_door = 1'b1; tick();
    status_door = 1'b0; floor = 4'd2;
    btn_car = 4'b1001; ticks(8);
    idle();
    chk("scan_req_in", int'(req_in), 4);
    chk("scan_dir", int'(dir), 0);
    floor = 4'd4; status_door = 1'b1; tick();
    status_door = 1'b0; ticks(2);
    chk("rev_req_in", int'(req_in), 1);
    chk("rev_dir", int'(dir), 1);
    floor = 4'd1; status_door = 1'b1; tick();
    idle();

    // hall call cleared on arrival, press during door-open ignored
    floor = 4'd1; btn_hall = 4'b1000; ticks(8);
    idle();
    chk("hall_set", int'(pending_hall), 4'b1000);
    floor = 4'd4; status_door = 1'b1; tick();
    chk("hall_clr", int'(pending_hall), 0);
    tick();
    chk("hall_req_out", int'(req_out), 0);
    btn_hall = 4'b1000; ticks(8);
    chk("door_press", int'(pending_hall), 0);
    idle();

    // press lands on the same edge as door-open at its floor
    floor = 4'd2; btn_car = 4'b0010; ticks(5);
    status_door = 1'b1; tick();
    chk("setclr_pcar", int'(pending_car), 0);
    status_door = 1'b0; ticks(3);
    chk("setclr_after", int'(pending_car), 0);
    idle();

    // SOS flushes calls and swallows presses
    floor = 4'd3; btn_car = 4'b1010; btn_hall = 4'b0001; ticks(8);
    idle();
    chk("sos_pre_car", int'(pending_car), 4'b1010);
    sos_en = 1'b1; tick();
    chk("sos_car", int'(pending_car), 0);
    chk("sos_hall", int'(pending_hall), 0);
    btn_car = 4'b0100; ticks(8);
    chk("sos_press", int'(pending_car), 0);
    chk("sos_req_in", int'(req_in), 0);
    sos_en = 1'b0; ticks(4);
    chk("sos_exit", int'(pending_car), 0);
    idle();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) btn_car[b] = ~btn_car[b];
        if ($urandom_range(0, 9) == 0) btn_hall[b] = ~btn_hall[b];
      end
      if ($urandom_range(0, 7) == 0) floor = 4'($urandom_range(0, 5));
      status_door = ($urandom_range(0, 3) == 0);
      if (sos_en) sos_en = ($urandom_range(0, 4) != 0);
      else        sos_en = ($urandom_range(0, 59) == 0);
      tick();
      if (c == 300) begin
        rst = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        btn_car = 4'b0001; btn_hall = '0;
        floor = 4'd3; status_door = 1'b0; sos_en = 1'b0;
        ticks(5);
        chk("rst_redeb0", int'(pending_car), 0);
        tick();
        chk("rst_redeb1", int'(pending_car), 4'b0001);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
